uart_rx_frame_ctrl: RTL and testbench

//  UART RX frame controller, directly upstream and downstream of the 3-sample majority sampler.

---
 rtl/uart_rx_frame_ctrl_if.sv | 45 ++++
 rtl/uart_rx_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART RX frame controller, its majority sampler and
// the byte consumer. The slave modport is the frame controller's view.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic              RX_IN;
    logic [4:0]        Prescale;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              sampled_bit;
    logic [4:0]        edge_counter;
    logic              data_sample_enable;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              parity_error;
    logic              stop_error;

    modport slave (
        input  RX_IN,
        input  Prescale,
        input  PAR_EN,
        input  PAR_TYP,
        input  sampled_bit,
        output edge_counter,
        output data_sample_enable,
        output P_DATA,
        output data_valid,
        output parity_error,
        output stop_error
    );

    modport master (
        output RX_IN,
        output Prescale,
        output PAR_EN,
        output PAR_TYP,
        output sampled_bit,
        input  edge_counter,
        input  data_sample_enable,
        input  P_DATA,
        input  data_valid,
        input  parity_error,
        input  stop_error
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detection, per-bit edge counter for the
// majority sampler, LSB-first deserialisation, optional parity and stop check.
module uart_rx_frame_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    uart_rx_frame_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            r_state;
    logic [4:0]        r_edge_cnt;
    logic [3:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_p_data;
    logic              r_par_bad;
    logic              r_data_valid;
    logic              r_parity_error;
    logic              r_stop_error;

    logic [5:0]        w_prescale_full;
    logic [4:0]        w_cp;
    logic [4:0]        w_last_edge;
    logic              w_at_cp;
    logic              w_wrap;
    logic              w_supported;
    logic              w_exp_parity;

    // The 5-bit Prescale port cannot hold 32, so the encoding 0 stands for 32.
    // Prescale-1 then naturally wraps to 31 in 5-bit arithmetic.
    assign w_prescale_full = (bus.Prescale == 5'd0) ? 6'd32 : {1'b0, bus.Prescale};
    assign w_cp            = w_prescale_full[5:1] + 5'd3;
    assign w_last_edge     = bus.Prescale - 5'd1;
    assign w_at_cp         = (r_edge_cnt == w_cp);
    assign w_wrap          = (r_edge_cnt == w_last_edge);
    assign w_supported     = (bus.Prescale == 5'd8) || (bus.Prescale == 5'd16) ||
                             (bus.Prescale == 5'd0);
    assign w_exp_parity    = (^r_shift) ^ bus.PAR_TYP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_edge_cnt     <= 5'd0;
            r_bit_cnt      <= 4'd0;
            r_shift        <= '0;
            r_p_data       <= '0;
            r_par_bad      <= 1'b0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;

            // Free-running bit timing outside IDLE; state arms below override it.
            if (r_state != IDLE) begin
                if (w_wrap) begin
                    r_edge_cnt <= 5'd0;
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                end else begin
                    r_edge_cnt <= r_edge_cnt + 5'd1;
                end
            end

            case (r_state)
                IDLE: begin
                    r_edge_cnt <= 5'd0;
                    if (!bus.RX_IN && w_supported) begin
                        r_state        <= START;
                        r_par_bad      <= 1'b0;
                        r_parity_error <= 1'b0;
                        r_stop_error   <= 1'b0;
                    end
                end

                START: begin
                    if (w_at_cp && bus.sampled_bit) begin
                        r_state    <= IDLE;
                        r_edge_cnt <= 5'd0;
                    end else if (w_wrap) begin
                        r_state   <= DATA;
                        r_bit_cnt <= 4'd0;
                    end
                end

                DATA: begin
                    if (w_at_cp) begin
                        r_shift <= {bus.sampled_bit, r_shift[DATA_W-1:1]};
                    end
                    if (w_wrap && (r_bit_cnt == 4'(DATA_W - 1))) begin
                        r_state <= bus.PAR_EN ? PARITY : STOP;
                    end
                end

                PARITY: begin
                    if (w_at_cp) begin
                        r_par_bad <= (bus.sampled_bit != w_exp_parity);
                    end
                    if (w_wrap) begin
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    // Leave at the consume point so a following start bit is not missed.
                    if (w_at_cp) begin
                        r_state    <= IDLE;
                        r_edge_cnt <= 5'd0;
                        if (!bus.sampled_bit) begin
                            r_stop_error <= 1'b1;
                        end else if (r_par_bad) begin
                            r_parity_error <= 1'b1;
                        end else begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_edge_cnt <= 5'd0;
                end
            endcase
        end
    end

    assign bus.edge_counter       = r_edge_cnt;
    assign bus.data_sample_enable = (r_state != IDLE);
    assign bus.P_DATA             = r_p_data;
    assign bus.data_valid         = r_data_valid;
    assign bus.parity_error       = r_parity_error;
    assign bus.stop_error         = r_stop_error;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: a majority-sampler model feeds sampled_bit, the
// stimulus queues expected frame outcomes and a negedge monitor scores them.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.DATA_W(8)) tif ();

    uart_rx_frame_ctrl #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         kind;   // 0 = data_valid, 1 = parity_error, 2 = stop_error
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    function automatic int full_p(input logic [4:0] p);
        return (p == 5'd0) ? 32 : int'(p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Sampler model: three samples around mid-bit, majority registered so it
    // is valid on the cycle where edge_counter == Prescale/2 + 3.
    logic [2:0] smp;
    always @(posedge clk or negedge rst) begin
        int h;
        if (!rst) begin
            smp             <= 3'b000;
            tif.sampled_bit <= 1'b0;
        end else if (!tif.data_sample_enable) begin
            smp <= 3'b000;
        end else begin
            h = full_p(tif.Prescale) / 2;
            if (int'(tif.edge_counter) == h - 1) smp[0] <= tif.RX_IN;
            if (int'(tif.edge_counter) == h)     smp[1] <= tif.RX_IN;
            if (int'(tif.edge_counter) == h + 1) smp[2] <= tif.RX_IN;
            if (int'(tif.edge_counter) == h + 2)
                tif.sampled_bit <= (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        end
    end

    // Scoreboard monitor
    logic mon_prev_pe = 1'b0;
    logic mon_prev_se = 1'b0;
    int   mon_prev_ec = 0;

    task automatic sb_event(input int kind, input logic [7:0] data);
        ev_t e;
        int  cp;
        cp = full_p(tif.Prescale) / 2 + 3;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d data=0x%0h expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 0 && e.data !== data)) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d data=0x%0h expected kind=%0d data=0x%0h",
                         kind, data, e.kind, e.data);
            end else begin
                $display("ok   sb_event: kind=%0d data=0x%0h", kind, data);
            end
        end
        check("latency_after_cp", 32'(mon_prev_ec), 32'(cp));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_prev_pe = 1'b0;
            mon_prev_se = 1'b0;
            mon_prev_ec = 0;
        end else begin
            if (tif.data_valid)                   sb_event(0, tif.P_DATA);
            if (tif.parity_error && !mon_prev_pe) sb_event(1, 8'h00);
            if (tif.stop_error && !mon_prev_se)   sb_event(2, 8'h00);
            mon_prev_pe = tif.parity_error;
            mon_prev_se = tif.stop_error;
            mon_prev_ec = int'(tif.edge_counter);
        end
    end

    // Stimulus: all drive happens at negedges
    task automatic drive_bit(input logic b);
        tif.RX_IN = b;
        repeat (full_p(tif.Prescale)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit,
                              input logic stop_bit, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (tif.PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
        tif.RX_IN = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_P_DATA"},       32'(tif.P_DATA), 32'h0);
        check({tag, "_data_valid"},   32'(tif.data_valid), 32'h0);
        check({tag, "_parity_error"}, 32'(tif.parity_error), 32'h0);
        check({tag, "_stop_error"},   32'(tif.stop_error), 32'h0);
        check({tag, "_edge_counter"}, 32'(tif.edge_counter), 32'h0);
        check({tag, "_enable"},       32'(tif.data_sample_enable), 32'h0);
    endtask

    initial begin
        int  last_ec;
        bit  seen;
        tif.RX_IN    = 1'b1;
        tif.Prescale = 5'd8;
        tif.PAR_EN   = 1'b0;
        tif.PAR_TYP  = 1'b0;

        repeat (3) @(negedge clk);
        check_all_quiet("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: Prescale 8, no parity, 0xA5
        push(0, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 24);
        check("t1_P_DATA", 32'(tif.P_DATA), 32'hA5);
        check("t1_no_err", 32'({tif.parity_error, tif.stop_error}), 32'h0);

        // 2: Prescale 16, even parity, 0x3C has four ones -> parity bit 0 is good
        tif.Prescale = 5'd16;
        tif.PAR_EN   = 1'b1;
        tif.PAR_TYP  = 1'b0;
        push(0, 8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, 32);
        check("t2_P_DATA", 32'(tif.P_DATA), 32'h3C);
        check("t2_parity_error", 32'(tif.parity_error), 32'h0);

        // 3: odd parity expected 1, line sends 0 -> parity error, byte kept
        tif.PAR_TYP = 1'b1;
        push(1, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b1, 32);
        check("t3_parity_error", 32'(tif.parity_error), 32'h1);
        check("t3_P_DATA_kept", 32'(tif.P_DATA), 32'h3C);

        // 4: Prescale 8, stop bit 0 -> stop error; next good frame clears it
        tif.Prescale = 5'd8;
        tif.PAR_EN   = 1'b0;
        tif.PAR_TYP  = 1'b0;
        push(2, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0, 24);
        check("t4_stop_error", 32'(tif.stop_error), 32'h1);
        check("t4_parity_cleared", 32'(tif.parity_error), 32'h0);
        check("t4_P_DATA_kept", 32'(tif.P_DATA), 32'h3C);
        push(0, 8'h0F);
        send_frame(8'h0F, 1'b0, 1'b1, 24);
        check("t4_stop_cleared", 32'(tif.stop_error), 32'h0);
        check("t4_P_DATA", 32'(tif.P_DATA), 32'h0F);

        // 5: glitch start at Prescale 16 -> abort at edge 11
        tif.Prescale = 5'd16;
        tif.RX_IN    = 1'b0;
        repeat (3) @(negedge clk);
        tif.RX_IN = 1'b1;
        last_ec = -1;
        seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tif.data_sample_enable) begin
                seen    = 1'b1;
                last_ec = int'(tif.edge_counter);
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
        check("t5_started", 32'(seen), 32'h1);
        check("t5_abort_edge", 32'(last_ec), 32'd11);
        check("t5_enable_low", 32'(tif.data_sample_enable), 32'h0);
        check("t5_P_DATA_kept", 32'(tif.P_DATA), 32'h0F);
        repeat (8) @(negedge clk);

        // Unsupported Prescale: line low must not start a frame
        tif.Prescale = 5'd12;
        tif.RX_IN    = 1'b0;
        seen         = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tif.data_sample_enable) seen = 1'b1;
        end
        tif.RX_IN = 1'b1;
        check("unsup_prescale_idle", 32'(seen), 32'h0);
        repeat (4) @(negedge clk);

        // 6: Prescale 32 (encoded 0), back-to-back frames, reset in the third
        tif.Prescale = 5'd0;
        push(0, 8'h01);
        push(0, 8'hFE);
        send_frame(8'h01, 1'b0, 1'b1, 0);
        send_frame(8'hFE, 1'b0, 1'b1, 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("t6_P_DATA_before_rst", 32'(tif.P_DATA), 32'hFE);
        check("t6_busy_before_rst", 32'(tif.data_sample_enable), 32'h1);
        #2 rst = 1'b0;
        #1 check_all_quiet("t6_after_rst");
        tif.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_idle_after_release", 32'(tif.data_sample_enable), 32'h0);

        check("sb_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got no finish expected finish before 2ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
